// File: rtl/crop_frame_writer_if.sv
// rtl/crop_frame_writer_if.sv - pixel stream and BRAM write-port interfaces for crop_frame_writer
interface pixel_stream_if;
    logic [7:0] pixel_i;
    logic       pixel_valid;

    modport master (output pixel_i, pixel_valid);
    modport slave  (input  pixel_i, pixel_valid);
endinterface

interface bram_wr_if;
    logic [31:0] bram_addr;
    logic [31:0] bram_data;
    logic [3:0]  write_enable;

    modport master (output bram_addr, bram_data, write_enable);
    modport slave  (input  bram_addr, bram_data, write_enable);
endinterface

// File: rtl/crop_frame_writer.sv
// rtl/crop_frame_writer.sv - packs 8-bit pixels into 32-bit words and writes ping-pong frames to BRAM
// Optional FRAME_WRITER_DROP_CNT_EN adds a saturating drop_count output.
module crop_frame_writer #(
    parameter int          IMG_W      = 32,
    parameter int          IMG_H      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          BUF_STRIDE = 4096
) (
    input  logic           clk,
    input  logic           reset,
    pixel_stream_if.slave  pix,
    bram_wr_if.master      bram,
    input  logic [1:0]     buf_release,
    output logic           frame_done,
    output logic           done_buf,
    output logic [1:0]     buf_full,
    output logic           overflow
`ifdef FRAME_WRITER_DROP_CNT_EN
    ,
    output logic [15:0]    drop_count
`endif
);
    localparam int          N    = IMG_W * IMG_H;
    localparam logic [16:0] LAST = 17'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, DROP, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] pix_cnt;
    logic        cur_buf, next_buf;
    logic [23:0] word_acc;

    logic        starting, start_fill, fill_pix, drop_pix, last_pix, tgt;
    logic [15:0] k;
    logic [31:0] word_nxt, wr_addr;
    logic [3:0]  lane_mask;
    logic [1:0]  rel_mask, set_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE also accepts the first pixel of the next frame, so it starts frames like IDLE.
    always_comb begin
        state_nxt = state;
        if (state == DONE) state_nxt = IDLE;
        if (fill_pix)      state_nxt = last_pix ? DONE : FILL;
        else if (drop_pix) state_nxt = last_pix ? IDLE : DROP;
    end

    always_comb begin
        starting   = (state == IDLE || state == DONE) && pix.pixel_valid;
        start_fill = starting && !buf_full[next_buf];
        fill_pix   = start_fill || (state == FILL && pix.pixel_valid);
        drop_pix   = (starting && buf_full[next_buf]) || (state == DROP && pix.pixel_valid);
        k          = starting ? 16'd0 : pix_cnt;
        last_pix   = ({1'b0, k} == LAST);
        tgt        = starting ? next_buf : cur_buf;
        case (k[1:0])
            2'd0:    word_nxt = {24'h0, pix.pixel_i};
            2'd1:    word_nxt = {16'h0, pix.pixel_i, word_acc[7:0]};
            2'd2:    word_nxt = {8'h0, pix.pixel_i, word_acc[15:0]};
            default: word_nxt = {pix.pixel_i, word_acc};
        endcase
        lane_mask = {k[1:0] == 2'd3, k[1], k[1:0] != 2'd0, 1'b1};
        wr_addr   = BASE_ADDR + (tgt ? 32'(BUF_STRIDE) : 32'd0) + {16'h0, k[15:2], 2'b00};
        rel_mask  = buf_release & ~((state == FILL) ? (cur_buf ? 2'b10 : 2'b01) : 2'b00);
        set_mask  = (fill_pix && last_pix) ? (tgt ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt           <= '0;
            cur_buf           <= 1'b0;
            next_buf          <= 1'b0;
            word_acc          <= '0;
            bram.bram_addr    <= '0;
            bram.bram_data    <= '0;
            bram.write_enable <= '0;
            frame_done        <= 1'b0;
            done_buf          <= 1'b0;
            buf_full          <= 2'b00;
            overflow          <= 1'b0;
        end else begin
            frame_done        <= 1'b0;
            bram.write_enable <= 4'h0;
            buf_full          <= (buf_full & ~rel_mask) | set_mask;
            if (fill_pix || drop_pix) pix_cnt <= last_pix ? 16'd0 : k + 16'd1;
            if (starting) cur_buf <= next_buf;
            if (starting && buf_full[next_buf]) overflow <= 1'b1;
            if (fill_pix) begin
                word_acc <= word_nxt[23:0];
                if (k[1:0] == 2'd3 || last_pix) begin
                    bram.bram_addr    <= wr_addr;
                    bram.bram_data    <= word_nxt;
                    bram.write_enable <= lane_mask;
                end
                if (last_pix) begin
                    frame_done <= 1'b1;
                    done_buf   <= tgt;
                    next_buf   <= ~next_buf;
                end
            end
        end
    end

`ifdef FRAME_WRITER_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_count <= '0;
        else if (starting && buf_full[next_buf] && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`endif
endmodule

// File: doc/crop_frame_writer.md
# crop_frame_writer

Downstream consumer of the resized-crop stage: accepts the 8-bit pixel stream (`pixel_i`/`pixel_valid`), packs four pixels per 32-bit word and writes complete cropped frames into the output BRAM. The output BRAM is split into two ping-pong frame buffers, so software can read one frame while the next is written. Frames arriving while the target buffer is still owned by software are dropped and flagged. The block sits between the crop engine and the output BRAM port of the block design.

## Interface
- `IMG_W`, 32, cropped frame width in pixels (1..256)
- `IMG_H`, 32, cropped frame height in pixels (1..256)
- `BASE_ADDR`, 32'h0, byte address of buffer 0
- `BUF_STRIDE`, 4096, byte offset from buffer 0 to buffer 1; multiple of 4, ≥ 4·ceil(IMG_W·IMG_H/4)
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `pixel_i`  in  8  pixel from crop stage
- `pixel_valid`  in  1  `pixel_i` valid this cycle; no backpressure
- `buf_release`  in  2  one-cycle pulse per bit: software has consumed buffer b
- `bram_addr`  out  32  output BRAM byte address
- `bram_data`  out  32  output BRAM write data
- `write_enable`  out  4  per-byte write strobe
- `frame_done`  out  1  one-cycle pulse: a frame is complete in BRAM
- `done_buf`  out  1  buffer index of the last completed frame
- `buf_full`  out  2  buffer b holds an unreleased frame
- `overflow`  out  1  sticky: at least one frame dropped; cleared only by reset

## Operation
- Frame = exactly N = IMG_W·IMG_H accepted pixels; the pixel counter is the only frame delimiter.
- States: IDLE, FILL, DROP, DONE.
- IDLE: on `pixel_valid`, if `buf_full[next_buf]`==0 then go to FILL targeting `next_buf`, else go to DROP and set `overflow`. The first pixel is counted in either case.
- FILL: pixel k (0-based) goes to byte lane k mod 4 (little-endian; pixel 0 is in bits 7:0). A word is written when lane 3 is filled, or when pixel N−1 arrives; a partial final word has strobes only on filled lanes (e.g. N mod 4 = 1 → `write_enable`=4'b0001). Word address = BASE_ADDR + buf·BUF_STRIDE + 4·(k div 4).
- After pixel N−1: go to DONE. DONE sets `buf_full[buf]`, pulses `frame_done`, loads `done_buf`, toggles `next_buf`, then returns to IDLE.
- DROP: count and discard pixels; after pixel N−1 return to IDLE with no write, no `frame_done`, and `next_buf` unchanged (strict alternation).
- `buf_release[b]` clears `buf_full[b]`. It is ignored for the buffer currently in FILL. A release and a DONE on different buffers in the same cycle both take effect.
- Reset (asynchronous, any state) returns all state to its reset value. A partially written frame is abandoned, and software treats both buffers as invalid.

## Timing
- Reset values: `bram_addr`=0, `bram_data`=0, `write_enable`=0, `frame_done`=0, `done_buf`=0, `buf_full`=2'b00, `overflow`=0; internally `next_buf`=0, state IDLE.
- Pixels are accepted every cycle `pixel_valid`=1, back-to-back, with no gap required between frames.
- Write latency: pixel accepted in cycle t completing a word → `bram_addr`/`bram_data`/`write_enable` registered and valid in cycle t+1. `write_enable` is nonzero for exactly one cycle per word and is 0 otherwise. `bram_addr` and `bram_data` hold their values between writes.
- Last pixel in cycle t → final write in t+1, `frame_done` high in t+1 only, `buf_full` bit set from t+1. The first pixel of the next frame may arrive in t+1; DONE evaluates `buf_full` one cycle later, so IDLE's check uses the updated value.
- `buf_release` is registered in its own cycle and takes effect from the next cycle.
- Ping-pong state is computed only in IDLE; a release arriving mid-DROP does not rescue the dropped frame.

## Configuration
- `FRAME_WRITER_DROP_CNT_EN` defined: adds output `drop_count` [15:0], a saturating count of dropped frames (increments on entry to DROP, stops at 16'hFFFF, reset to 0).
- Not defined: the `drop_count` port and its logic are absent; only the sticky `overflow` flag reports drops.

## Test plan
- IMG_W=4, IMG_H=3, pixels 0x01..0x0C streamed back-to-back → three writes: addr 0x0 data 0x04030201, addr 0x4 data 0x08070605, addr 0x8 data 0x0C0B0A09, each with `write_enable`=4'hF; `frame_done` coincides with the third write; `done_buf`=0; `buf_full`=2'b01.
- IMG_W=5, IMG_H=1, pixels 0xA0..0xA4 → write 0x0 = 0xA3A2A1A0 (strobe 4'hF), then write 0x4 with byte 0 = 0xA4 and strobe 4'b0001.
- Two back-to-back frames (4×3) with no release → second frame is written at BASE_ADDR+0x1000; `buf_full`=2'b11. A third frame produces no writes and sets `overflow`=1. After `buf_release`=2'b01, the fourth frame is written to buffer 0.
- `buf_release[1]` pulsed while buffer 1 is in FILL → no effect; `buf_full[1]`=1 after that frame completes.
- Reset asserted after pixel 6 of a 4×3 frame → all outputs at reset values immediately; the next 12 pixels are written starting at addr 0x0.
- With `FRAME_WRITER_DROP_CNT_EN`: 3 frames dropped → `drop_count`=3; the count holds at 16'hFFFF when forced near saturation.
